// File: rtl/xy2_pkg.sv
// XY2-100 shared constants, types and frame builder.
// Used by the transmitter and the existing receiver.
package xy2_pkg;

    localparam logic [2:0] XY2_CTRL       = 3'b001;
    localparam int         XY2_FRAME_BITS = 20;
    localparam int         XY2_DATA_BITS  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } xy2_state_e;

    typedef logic [XY2_FRAME_BITS-1:0] xy2_frame_t;

    typedef struct packed {
        logic [XY2_DATA_BITS-1:0] x;
        logic [XY2_DATA_BITS-1:0] y;
    } xy2_pair_t;

    // Control, data, then even parity over the 19 bits before it.
    function automatic xy2_frame_t xy2_frame(
        input logic [XY2_DATA_BITS-1:0] d
    );
        return {XY2_CTRL, d, ^{XY2_CTRL, d}};
    endfunction

endpackage

// File: rtl/xy2_bit_timer.sv
// XY2-100 bit timer: half-period divider and bit index.
// The LOAD cycle counts as the first cycle of bit 0.
module xy2_bit_timer #(
    parameter int CLK_DIV = 5
) (
    input  logic       clk_ref,
    input  logic       sys_rstn,
    input  logic       start,
    input  logic       run,
    output logic       phase,
    output logic [4:0] bit_idx,
    output logic       bit_end,
    output logic       frame_end
);
    import xy2_pkg::*;

    localparam logic [7:0] DIV_M1   = 8'(CLK_DIV - 1);
    localparam logic [4:0] LAST_BIT = 5'(XY2_FRAME_BITS - 1);

    logic [7:0] cnt;
    logic       half_end;

    assign half_end  = run && (cnt == DIV_M1);
    assign bit_end   = half_end && phase;
    assign frame_end = bit_end && (bit_idx == LAST_BIT);

    // Divider and bit counter; start pre-counts the LOAD cycle
    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            cnt     <= 8'd0;
            phase   <= 1'b0;
            bit_idx <= 5'd0;
        end else if (start) begin
            cnt     <= 8'd1;
            phase   <= 1'b0;
            bit_idx <= 5'd0;
        end else if (half_end) begin
            cnt   <= 8'd0;
            phase <= !phase;
            if (phase) begin
                bit_idx <= bit_idx + 5'd1;
            end
        end else if (run) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/xy2_tx.sv
// XY2-100 transmitter: setpoint handshake, frame FSM,
// parity and X/Y shift registers.
module xy2_tx #(
    parameter int          CLK_DIV   = 5,
    parameter logic [15:0] POS_RESET = 16'h8000
) (
    input  logic        clk_ref,
    input  logic        sys_rstn,
    input  logic        enable,
    input  logic [15:0] x_pos,
    input  logic [15:0] y_pos,
    input  logic        pos_valid,
    output logic        pos_ready,
    output logic        xy_clk,
    output logic        xy_sync,
    output logic        xy_x,
    output logic        xy_y,
    output logic        frame_done
);
    import xy2_pkg::*;

    localparam int         MSB      = XY2_FRAME_BITS - 1;
    localparam logic [4:0] LAST_BIT = 5'(XY2_FRAME_BITS - 1);

    xy2_state_e state;
    xy2_state_e state_nxt;
    xy2_pair_t  act;
    xy2_pair_t  pend;
    xy2_pair_t  sel;
    logic       pend_full;
    logic       accept;
    xy2_frame_t frame_x;
    xy2_frame_t frame_y;
    xy2_frame_t sh_x;
    xy2_frame_t sh_y;
    logic       phase;
    logic [4:0] bit_idx;
    logic       bit_end;
    logic       frame_end;

    assign pos_ready = !pend_full;
    assign accept    = pos_valid && !pend_full;
    assign sel       = pend_full ? pend : act;
    assign frame_x   = xy2_frame(sel.x);
    assign frame_y   = xy2_frame(sel.y);

    xy2_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk_ref   (clk_ref),
        .sys_rstn  (sys_rstn),
        .start     (state == ST_LOAD),
        .run       (state == ST_SHIFT),
        .phase     (phase),
        .bit_idx   (bit_idx),
        .bit_end   (bit_end),
        .frame_end (frame_end)
    );

    // FSM state register
    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; enable only matters in IDLE and at frame end
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (enable) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                if (frame_end) begin
                    state_nxt = enable ? ST_LOAD : ST_IDLE;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Active/pending setpoints; LOAD promotes a full pending pair
    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            act       <= {POS_RESET, POS_RESET};
            pend      <= '0;
            pend_full <= 1'b0;
        end else begin
            if (state == ST_LOAD && pend_full) begin
                act       <= pend;
                pend_full <= 1'b0;
            end
            if (accept) begin
                pend      <= {x_pos, y_pos};
                pend_full <= 1'b1;
            end
        end
    end

    // Frame shift registers, MSB leaves first
    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            sh_x <= '0;
            sh_y <= '0;
        end else if (state == ST_LOAD) begin
            sh_x <= frame_x;
            sh_y <= frame_y;
        end else if (bit_end) begin
            sh_x <= {sh_x[MSB-1:0], 1'b0};
            sh_y <= {sh_y[MSB-1:0], 1'b0};
        end
    end

    // Line outputs; bit 0 is already on the wire during LOAD
    always_comb begin
        xy_clk     = 1'b0;
        xy_sync    = 1'b0;
        xy_x       = 1'b0;
        xy_y       = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            ST_LOAD: begin
                xy_clk  = 1'b1;
                xy_sync = 1'b1;
                xy_x    = frame_x[MSB];
                xy_y    = frame_y[MSB];
            end
            ST_SHIFT: begin
                xy_clk     = !phase;
                xy_sync    = (bit_idx != LAST_BIT);
                xy_x       = sh_x[MSB];
                xy_y       = sh_y[MSB];
                frame_done = frame_end;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_xy2_tx.sv
// Bench for xy2_tx: frame-level model feeds a scoreboard,
// an XY2 receiver monitor pops and compares each frame.
`timescale 1ns/1ps
module tb_xy2_tx;

    localparam int CLK_DIV   = 5;
    localparam int FRAME_CYC = 2 * CLK_DIV * 20;

    logic        clk_ref   = 1'b0;
    logic        sys_rstn  = 1'b0;
    logic        enable    = 1'b0;
    logic [15:0] x_pos     = 16'h0;
    logic [15:0] y_pos     = 16'h0;
    logic        pos_valid = 1'b0;
    logic        pos_ready;
    logic        xy_clk;
    logic        xy_sync;
    logic        xy_x;
    logic        xy_y;
    logic        frame_done;

    xy2_tx #(
        .CLK_DIV   (CLK_DIV),
        .POS_RESET (16'h8000)
    ) dut (
        .clk_ref    (clk_ref),
        .sys_rstn   (sys_rstn),
        .enable     (enable),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .pos_valid  (pos_valid),
        .pos_ready  (pos_ready),
        .xy_clk     (xy_clk),
        .xy_sync    (xy_sync),
        .xy_x       (xy_x),
        .xy_y       (xy_y),
        .frame_done (frame_done)
    );

    always #5 clk_ref = ~clk_ref;

    int n_checks = 0;
    int n_pass   = 0;

    logic [39:0] sb[$];

    function automatic logic [19:0] mk(input logic [15:0] d);
        logic p;
        p = 1'b1;
        for (int i = 0; i < 16; i++) p = p ^ d[i];
        return {3'b001, d, p};
    endfunction

    // Frame-level reference model
    int          m_state = 0;
    int          m_cnt   = 0;
    logic [15:0] m_act_x = 16'h8000;
    logic [15:0] m_act_y = 16'h8000;
    logic [15:0] m_pend_x = 16'h0;
    logic [15:0] m_pend_y = 16'h0;
    logic        m_pfull = 1'b0;

    always @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            m_state <= 0;
            m_cnt   <= 0;
            m_act_x <= 16'h8000;
            m_act_y <= 16'h8000;
            m_pfull <= 1'b0;
            sb.delete();
        end else begin
            case (m_state)
                0: if (enable) m_state <= 1;
                1: begin
                    if (m_pfull) begin
                        sb.push_back({mk(m_pend_x), mk(m_pend_y)});
                        m_act_x <= m_pend_x;
                        m_act_y <= m_pend_y;
                    end else begin
                        sb.push_back({mk(m_act_x), mk(m_act_y)});
                    end
                    m_state <= 2;
                    m_cnt   <= 1;
                end
                default: begin
                    m_cnt <= m_cnt + 1;
                    if (m_cnt == FRAME_CYC - 1) m_state <= enable ? 1 : 0;
                end
            endcase
            if (pos_valid && !m_pfull) begin
                m_pend_x <= x_pos;
                m_pend_y <= y_pos;
                m_pfull  <= 1'b1;
            end else if (m_state == 1 && m_pfull) begin
                m_pfull <= 1'b0;
            end
        end
    end

    // Receiver monitor: samples on xy_clk falling edge
    logic        mon_prev = 1'b0;
    int          mon_n    = 0;
    logic [19:0] mon_x    = '0;
    logic [19:0] mon_y    = '0;
    logic [19:0] last_rx_x = '0;
    logic [19:0] last_rx_y = '0;
    int          n_frames = 0;

    always @(negedge clk_ref) begin : monitor
        logic [19:0] nx;
        logic [19:0] ny;
        logic [39:0] exp_f;
        if (!sys_rstn) begin
            mon_prev <= 1'b0;
            mon_n    <= 0;
        end else begin
            mon_prev <= xy_clk;
            if (mon_prev && !xy_clk) begin
                nx = {mon_x[18:0], xy_x};
                ny = {mon_y[18:0], xy_y};
                mon_x <= nx;
                mon_y <= ny;
                if (xy_sync) begin
                    mon_n <= mon_n + 1;
                end else begin
                    mon_n     <= 0;
                    n_frames  <= n_frames + 1;
                    last_rx_x <= nx;
                    last_rx_y <= ny;
                    n_checks++;
                    if (mon_n != 19) begin
                        $display("FAIL frame_len got %0d sync-high bits want 19", mon_n);
                    end else if (sb.size() == 0) begin
                        $display("FAIL frame_unexpected got x=%b y=%b want none", nx, ny);
                    end else begin
                        exp_f = sb.pop_front();
                        if ({nx, ny} !== exp_f)
                            $display("FAIL frame_data got x=%b y=%b want x=%b y=%b",
                                     nx, ny, exp_f[39:20], exp_f[19:0]);
                        else
                            n_pass++;
                    end
                end
            end
        end
    end

    task automatic wait_fd(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk_ref);
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_frames(input int target, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk_ref);
            if (n_frames >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        sys_rstn  = 1'b0;
        enable    = 1'b0;
        pos_valid = 1'b0;
        repeat (3) @(negedge clk_ref);
        n_checks++;
        if (xy_clk !== 1'b0) $display("FAIL rst_clk got %b want 0", xy_clk); else n_pass++;
        n_checks++;
        if (xy_sync !== 1'b0) $display("FAIL rst_sync got %b want 0", xy_sync); else n_pass++;
        n_checks++;
        if (xy_x !== 1'b0) $display("FAIL rst_x got %b want 0", xy_x); else n_pass++;
        n_checks++;
        if (xy_y !== 1'b0) $display("FAIL rst_y got %b want 0", xy_y); else n_pass++;
        n_checks++;
        if (frame_done !== 1'b0) $display("FAIL rst_done got %b want 0", frame_done); else n_pass++;
        n_checks++;
        if (pos_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", pos_ready); else n_pass++;
    endtask

    task automatic test_idle_frames();
        bit ok;
        int cyc;
        int sync_hi;
        int rises;
        int r0;
        int r1;
        logic pc;
        sys_rstn = 1'b1;
        @(negedge clk_ref);
        enable = 1'b1;
        wait_fd(600, ok);
        n_checks++;
        if (!ok) $display("FAIL idle_first_done got timeout want pulse"); else n_pass++;
        cyc = 0; sync_hi = 0; rises = 0; r0 = 0; r1 = 0;
        pc = xy_clk;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_ref);
            cyc++;
            if (xy_sync) sync_hi++;
            if (xy_clk && !pc) begin
                if (rises == 0) r0 = cyc;
                if (rises == 1) r1 = cyc;
                rises++;
            end
            pc = xy_clk;
            if (frame_done) break;
        end
        n_checks++;
        if (cyc != 200) $display("FAIL done_period got %0d want 200", cyc); else n_pass++;
        n_checks++;
        if (sync_hi != 190) $display("FAIL sync_high got %0d want 190", sync_hi); else n_pass++;
        n_checks++;
        if (rises != 20) $display("FAIL clk_rises got %0d want 20", rises); else n_pass++;
        n_checks++;
        if (r1 - r0 != 10) $display("FAIL clk_period got %0d want 10", r1 - r0); else n_pass++;
        wait_frames(3, 800, ok);
        n_checks++;
        if (!ok) $display("FAIL idle_frames got %0d want 3", n_frames); else n_pass++;
        n_checks++;
        if (last_rx_x !== 20'b00110000000000000000 || last_rx_y !== 20'b00110000000000000000)
            $display("FAIL idle_content got x=%b y=%b want 00110000000000000000", last_rx_x, last_rx_y);
        else n_pass++;
    endtask

    task automatic test_accept_mid_frame();
        bit ok;
        int base;
        wait_fd(400, ok);
        n_checks++;
        if (!ok) $display("FAIL acc_sync got timeout want frame_done"); else n_pass++;
        repeat (50) @(negedge clk_ref);
        n_checks++;
        if (pos_ready !== 1'b1) $display("FAIL acc_ready_before got %b want 1", pos_ready); else n_pass++;
        base = n_frames;
        x_pos = 16'h1234; y_pos = 16'hFFFF; pos_valid = 1'b1;
        @(negedge clk_ref);
        pos_valid = 1'b0;
        n_checks++;
        if (pos_ready !== 1'b0) $display("FAIL acc_ready_after got %b want 0", pos_ready); else n_pass++;
        wait_frames(base + 2, 700, ok);
        n_checks++;
        if (ok !== 1'b1 || last_rx_x !== 20'b00100010010001101000 || last_rx_y !== 20'b00111111111111111111)
            $display("FAIL acc_next got x=%b y=%b want 00100010010001101000/00111111111111111111", last_rx_x, last_rx_y);
        else n_pass++;
        wait_frames(base + 3, 400, ok);
        n_checks++;
        if (ok !== 1'b1 || last_rx_x !== 20'b00100010010001101000 || last_rx_y !== 20'b00111111111111111111)
            $display("FAIL acc_repeat got x=%b y=%b want 00100010010001101000/00111111111111111111", last_rx_x, last_rx_y);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int base;
        int fd_at;
        int rd_at;
        wait_fd(400, ok);
        repeat (30) @(negedge clk_ref);
        base = n_frames;
        x_pos = 16'hA5A5; y_pos = 16'h0001; pos_valid = 1'b1;
        @(negedge clk_ref);
        n_checks++;
        if (pos_ready !== 1'b0) $display("FAIL b2b_ready_drop got %b want 0", pos_ready); else n_pass++;
        x_pos = 16'h0F0F; y_pos = 16'h7FFE;
        fd_at = -100; rd_at = -1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk_ref);
            if (frame_done) fd_at = i;
            if (pos_ready) begin
                rd_at = i;
                break;
            end
        end
        @(negedge clk_ref);
        pos_valid = 1'b0;
        n_checks++;
        if (rd_at - fd_at != 2) $display("FAIL b2b_b_accept got %0d want 2 cycles after frame_done", rd_at - fd_at);
        else n_pass++;
        wait_frames(base + 2, 700, ok);
        n_checks++;
        if (ok !== 1'b1 || last_rx_x !== mk(16'hA5A5) || last_rx_y !== mk(16'h0001))
            $display("FAIL b2b_a got x=%b y=%b want %b/%b", last_rx_x, last_rx_y, mk(16'hA5A5), mk(16'h0001));
        else n_pass++;
        wait_frames(base + 3, 400, ok);
        n_checks++;
        if (ok !== 1'b1 || last_rx_x !== mk(16'h0F0F) || last_rx_y !== mk(16'h7FFE))
            $display("FAIL b2b_b got x=%b y=%b want %b/%b", last_rx_x, last_rx_y, mk(16'h0F0F), mk(16'h7FFE));
        else n_pass++;
    endtask

    task automatic test_load_collision();
        bit ok;
        int base;
        wait_fd(400, ok);
        @(negedge clk_ref);
        n_checks++;
        if (pos_ready !== 1'b1) $display("FAIL col_ready got %b want 1", pos_ready); else n_pass++;
        base = n_frames;
        x_pos = 16'hC3C3; y_pos = 16'h0000; pos_valid = 1'b1;
        @(negedge clk_ref);
        pos_valid = 1'b0;
        wait_frames(base + 1, 400, ok);
        n_checks++;
        if (ok !== 1'b1 || last_rx_x !== mk(16'h0F0F) || last_rx_y !== mk(16'h7FFE))
            $display("FAIL col_old got x=%b y=%b want %b/%b", last_rx_x, last_rx_y, mk(16'h0F0F), mk(16'h7FFE));
        else n_pass++;
        wait_frames(base + 2, 400, ok);
        n_checks++;
        if (ok !== 1'b1 || last_rx_x !== mk(16'hC3C3) || last_rx_y !== 20'b00100000000000000001)
            $display("FAIL col_new got x=%b y=%b want %b/00100000000000000001", last_rx_x, last_rx_y, mk(16'hC3C3));
        else n_pass++;
    endtask

    task automatic test_enable_drop();
        bit ok;
        int base;
        int bad;
        wait_fd(400, ok);
        repeat (55) @(negedge clk_ref);
        enable = 1'b0;
        base = n_frames;
        wait_fd(300, ok);
        n_checks++;
        if (!ok) $display("FAIL drop_done got timeout want pulse"); else n_pass++;
        @(negedge clk_ref);
        n_checks++;
        if (n_frames != base + 1 || last_rx_x !== mk(16'hC3C3))
            $display("FAIL drop_full_frame got n=%0d x=%b want n=%0d x=%b", n_frames, last_rx_x, base + 1, mk(16'hC3C3));
        else n_pass++;
        bad = 0;
        repeat (50) begin
            @(negedge clk_ref);
            if (xy_clk || xy_sync || xy_x || xy_y || frame_done) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL drop_idle_low got %0d active cycles want 0", bad); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int base;
        enable = 1'b1;
        wait_fd(500, ok);
        repeat (102) @(negedge clk_ref);
        n_checks++;
        if ({xy_clk, xy_sync, xy_x} !== 3'b111)
            $display("FAIL rmid_pre got %b want 111", {xy_clk, xy_sync, xy_x});
        else n_pass++;
        #1 sys_rstn = 1'b0;
        #1;
        n_checks++;
        if ({xy_clk, xy_sync, xy_x, xy_y, frame_done} !== 5'b00000)
            $display("FAIL rmid_outs got %b want 00000", {xy_clk, xy_sync, xy_x, xy_y, frame_done});
        else n_pass++;
        n_checks++;
        if (pos_ready !== 1'b1) $display("FAIL rmid_ready got %b want 1", pos_ready); else n_pass++;
        repeat (3) @(negedge clk_ref);
        sys_rstn = 1'b1;
        base = n_frames;
        wait_frames(base + 2, 700, ok);
        n_checks++;
        if (ok !== 1'b1 || last_rx_x !== 20'b00110000000000000000 || last_rx_y !== 20'b00110000000000000000)
            $display("FAIL rmid_after got x=%b y=%b want 00110000000000000000", last_rx_x, last_rx_y);
        else n_pass++;
    endtask

    task automatic test_drain();
        bit ok;
        enable = 1'b0;
        wait_fd(300, ok);
        repeat (5) @(negedge clk_ref);
        n_checks++;
        if (!ok || sb.size() != 0)
            $display("FAIL drain got done=%0d left=%0d want done=1 left=0", ok, sb.size());
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_idle_frames();
        test_accept_mid_frame();
        test_back_to_back();
        test_load_collision();
        test_enable_drop();
        test_reset_mid_frame();
        test_drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
